// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg
// Shared definitions for the four-way round-robin arbiter.
//   arbState_e : arbiter FSM states (IDLE, GRANT, GAP)
//   NREQ       : number of requesters
//   LAST_RESET : last-owner pointer value after reset; with 3 here,
//                requester 0 has first priority once reset is released
//   oneHot     : converts a requester index into a one-hot grant vector
package rr_arb_pkg;

  localparam int NREQ = 4;

  localparam logic [1:0] LAST_RESET = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arbState_e;

  // One-hot grant vector for a requester index.
  function automatic logic [NREQ-1:0] oneHot(input logic [1:0] idx);
    oneHot = '0;
    oneHot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rr_pick4
// Combinational round-robin picker. Searches the requesters starting one
// past the last owner and wrapping modulo 4, so the last owner is
// considered last of all.
//   req_i    in  4  active requests
//   last_i   in  2  index of the most recent owner
//   winner_o out 2  index of the winning requester (0 when none)
//   valid_o  out 1  high when at least one request is active
import rr_arb_pkg::*;

module rr_pick4 (
  input  logic [NREQ-1:0] req_i,
  input  logic [1:0]      last_i,
  output logic [1:0]      winner_o,
  output logic            valid_o
);

  logic [1:0] cand;

  // Walk the candidates from lowest to highest priority, so the
  // highest-priority active requester is the one that sticks. The 2-bit
  // add provides the wrap from 3 back to 0, and the offset of 4 wraps
  // onto the last owner itself.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    cand     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = last_i + 2'(k);
      if (req_i[cand]) begin
        winner_o = cand;
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// rr_arbiter4
// Moore round-robin arbiter sharing one resource among four requesters.
// A winner keeps the grant until it pulses DONE or drops its request.
// Every handoff passes through exactly one GAP cycle with no grant.
// All outputs come straight from registers.
//
// Ports:
//   CLK     in  1  rising-edge clock
//   RESET   in  1  synchronous active-high reset
//   REQ     in  4  level requests, held until granted
//   DONE    in  1  owner release pulse, honoured only in GRANT
//   GNT     out 4  one-hot grant or 0000
//   OWNER   out 2  current or most recent owner
//   BUSY    out 1  high in GRANT and GAP
//   TIMEOUT out 1  one-cycle pulse during the GAP after a forced release
//
// Build option: define RR_ARBITER4_TIMEOUT_EN to enable the hold counter.
// A grant is then force-released after MAX_HOLD cycles. Without the macro
// no counter is built, TIMEOUT is tied low, and MAX_HOLD and CNT_W have
// no effect.
import rr_arb_pkg::*;

module rr_arbiter4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [NREQ-1:0] REQ,
  input  logic            DONE,
  output logic [NREQ-1:0] GNT,
  output logic [1:0]      OWNER,
  output logic            BUSY,
  output logic            TIMEOUT
);

  arbState_e       state_q;
  logic [NREQ-1:0] gnt_q;
  logic [1:0]      owner_q;
  logic [1:0]      last_q;
  logic            busy_q;
  logic            timeout_q;

  logic [1:0]      pickIdx_d;
  logic            pickValid_d;
  logic            timeoutHit;
  logic            releaseNow;

  rr_pick4 u_pick (
    .req_i    (REQ),
    .last_i   (last_q),
    .winner_o (pickIdx_d),
    .valid_o  (pickValid_d)
  );

`ifdef RR_ARBITER4_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] holdCnt_q;

  // The counter is cleared when a grant starts. It reads MAX_HOLD-1
  // during the last cycle a grant may last.
  assign timeoutHit = (holdCnt_q == HOLD_LAST);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      holdCnt_q <= '0;
    end else if (state_q == GRANT) begin
      if (holdCnt_q != '1) begin
        holdCnt_q <= holdCnt_q + CNT_W'(1);
      end
    end else begin
      holdCnt_q <= '0;
    end
  end
`else
  logic unusedCfg;

  assign unusedCfg  = ^{MAX_HOLD, CNT_W};
  assign timeoutHit = 1'b0;
`endif

  // Any of the three release causes ends the grant at the next edge.
  assign releaseNow = DONE || !REQ[owner_q] || timeoutHit;

  // Main FSM with registered outputs. IDLE and GAP arbitrate identically.
  // The only difference is what happens when nobody is requesting.
  // TIMEOUT is reported only for a forced release that DONE did not
  // also cover.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      last_q    <= LAST_RESET;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE, GAP: begin
          if (pickValid_d) begin
            state_q <= GRANT;
            owner_q <= pickIdx_d;
            gnt_q   <= oneHot(pickIdx_d);
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
        GRANT: begin
          if (releaseNow) begin
            state_q   <= GAP;
            last_q    <= owner_q;
            gnt_q     <= '0;
            busy_q    <= 1'b1;
            timeout_q <= timeoutHit && !DONE;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign GNT     = gnt_q;
  assign OWNER   = owner_q;
  assign BUSY    = busy_q;
  assign TIMEOUT = timeout_q;

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Moore-style round-robin arbiter that shares one resource among four requesters. It sits in front of the shared datapath and decides which requester owns it; every output comes from a register. Ownership is held until the owner releases it. An optional timeout can force release. Fairness uses a rotating last-owner pointer.

## Interface
- MAX_HOLD, default 8: maximum grant length in cycles; used only when the timeout is compiled in; legal range 2..2^CNT_W.
- CNT_W, default 4: width of the hold counter.

- CLK  in  1  rising-edge clock.
- RESET  in  1  synchronous, active-high reset; sampled on the CLK rising edge.
- REQ  in  4  request per requester; level, held until granted.
- DONE  in  1  owner release pulse; valid only while BUSY and GNT are nonzero.
- GNT  out  4  one-hot grant, or 0000.
- OWNER  out  2  index of the current or most recent owner.
- BUSY  out  1  high in GRANT and GAP.
- TIMEOUT  out  1  one-cycle pulse when a grant is force-released.

## Operation
- **States:** IDLE, GRANT, GAP. State is kept in a registered enum; outputs depend on state and registers only.
- **Priority order:** LAST+1, LAST+2, LAST+3, LAST, all mod 4. Index 3 wraps to 0.
- **IDLE**
  - Outputs: GNT=0000, BUSY=0.
  - If REQ≠0: pick the winner, load OWNER, clear hold_cnt, go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT**
  - Outputs: GNT = one-hot(OWNER), BUSY=1; hold_cnt increments each cycle and saturates.
  - Release occurs when DONE=1, or REQ[OWNER]=0, or a timeout fires.
  - On release: LAST<=OWNER, go to GAP.
- **GAP**
  - Outputs: GNT=0000, BUSY=1. This is exactly one dead cycle between owners.
  - Arbitrates the same way as IDLE: if REQ≠0, go to GRANT with the new pick; otherwise go to IDLE.
  - The previous owner may win again only if it is the only requester.
- **Simultaneous events**
  - DONE and a timeout in the same cycle: treat as a DONE release; TIMEOUT stays 0.
  - DONE asserted while not in GRANT is ignored.
- **Non-owner requests:** REQ changes on non-owners during GRANT have no effect.
- **Reset**
  - Values on the reset edge: state=IDLE, GNT=0000, OWNER=00, BUSY=0, TIMEOUT=0, hold_cnt=0, LAST=3. With LAST=3, requester 0 has first priority after reset.
  - Reset asserted mid-grant: GNT drops at that same edge. No TIMEOUT is produced and no release is reported.

## Timing
- REQ sampled high in IDLE: GNT is high from the next rising edge (1-cycle latency).
- DONE sampled at edge k: GNT=0000 after edge k (GAP). The next owner's GNT is high after edge k+1.
- Back-to-back handoff cost: exactly 1 cycle with GNT=0000.
- Grant length with the timeout enabled: at most MAX_HOLD cycles. TIMEOUT is high during the GAP cycle that follows a forced release.

## Configuration
- Macro: RR_ARBITER4_TIMEOUT_EN.
- **Defined:** when hold_cnt reaches MAX_HOLD-1 in GRANT without DONE, force release at the next edge. TIMEOUT then pulses for one cycle (during GAP) and the pointer advances as usual.
- **Undefined:**
  - No hold counter logic is built.
  - A grant lasts until DONE or until the owner drops REQ.
  - TIMEOUT is tied to 0.
  - MAX_HOLD and CNT_W are ignored.

## Structure
- **Package rr_arb_pkg:**
  - state enum {IDLE, GRANT, GAP};
  - NREQ=4 constant;
  - reset value of LAST (3).
- **Sub-module rr_pick4 (combinational):** takes REQ[3:0] and LAST[1:0]; returns the winning index and a valid flag. All rotation and wrap logic lives here.
- **Top level:** FSM, OWNER/LAST registers, hold counter.

## Test plan
1. Reset: RESET=1 for 2 cycles with REQ=1111 -> GNT=0000, BUSY=0, OWNER=0, TIMEOUT=0 throughout.
2. Single request: REQ=0100 after reset -> GNT=0100, OWNER=2 one edge later. Pulse DONE -> GNT=0000 with BUSY=1 for 1 cycle, then BUSY=0.
3. Rotation: REQ=1111 held, DONE pulsed 2 cycles into each grant -> grant order 0,1,2,3,0. Each grant is separated by exactly one GNT=0000 cycle.
4. Implicit release: owner 1 (REQ=0010) drops REQ with DONE=0 -> GAP, then IDLE. The next REQ=0011 grants requester 0 first, because priority after LAST=1 runs 2,3,0,1 and 0 is the first active requester.
5. Timeout (macro defined, MAX_HOLD=8): REQ=0011 held, DONE=0 -> GNT=0001 for exactly 8 cycles. Then TIMEOUT=1 for 1 cycle with GNT=0000, then GNT=0010. Same stimulus with the macro undefined: GNT=0001 indefinitely, TIMEOUT=0.
6. Mid-grant reset: RESET=1 while GNT=0100 -> GNT=0000, BUSY=0 at that edge. After release with REQ=1001, requester 0 is granted first.
